// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues loads/stores on a req/ack bus, stalls upstream while waiting, registers the write-back result.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of issuing them.
module mem_stage #(
  parameter int RegWidth      = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iValid,
  input  logic                iLoad,
  input  logic                iStore,
  input  logic [2:0]          iFunc3,
  input  logic [4:0]          iRdAddr,
  input  logic                iRdWrEn,
  input  logic [RegWidth-1:0] iAluZ,
  input  logic [RegWidth-1:0] iStoreData,
  output logic                oStall,
  output logic                oMemReq,
  output logic                oMemWe,
  output logic [RegWidth-1:0] oMemAddr,
  output logic [3:0]          oMemBe,
  output logic [RegWidth-1:0] oMemWData,
  input  logic                iMemAck,
  input  logic                iMemErr,
  input  logic [RegWidth-1:0] iMemRData,
  output logic                oValid,
  output logic                oRdWrEn,
  output logic [4:0]          oRdAddr,
  output logic [RegWidth-1:0] oRdValue,
  output logic                oFault
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CntW-1:0]       r_cnt;
  logic                  r_valid;
  logic                  r_rdWrEn;
  logic [4:0]            r_rdAddr;
  logic [RegWidth-1:0]   r_rdValue;
  logic                  r_fault;

  logic                  w_memOp;
  logic                  w_misalign;
  logic                  w_trap;
  logic                  w_timeout;
  logic                  w_req;
  logic                  w_stall;
  logic                  w_done;
  logic                  w_fault;
  logic                  w_reqOut;
  logic [1:0]            w_bo;
  logic [3:0]            w_be;
  logic [RegWidth-1:0]   w_wdata;

  // Lane extraction with sign/zero extension for LB/LBU/LH/LHU/LW.
  function automatic logic [RegWidth-1:0] load_extract(input logic [2:0] f3,
                                                       input logic [1:0] bo,
                                                       input logic [RegWidth-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{bo, 3'b000} +: 8];
    h = rd[{bo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{(RegWidth-8){b[7]}}, b};
      3'b100:  load_extract = {{(RegWidth-8){1'b0}}, b};
      3'b001:  load_extract = {{(RegWidth-16){h[15]}}, h};
      3'b101:  load_extract = {{(RegWidth-16){1'b0}}, h};
      3'b010:  load_extract = rd;
      default: load_extract = rd;
    endcase
  endfunction

  assign w_bo       = iAluZ[1:0];
  assign w_memOp    = iValid & (iLoad | iStore);
  assign w_misalign = ((iFunc3[1:0] == 2'b01) & w_bo[0]) |
                      ((iFunc3[1:0] == 2'b10) & (w_bo != 2'b00));
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap     = w_memOp & w_misalign;
`else
  assign w_trap     = 1'b0;
`endif
  assign w_timeout  = (TimeoutCycles != 0) && (r_state == WAIT) && (r_cnt == TimeoutVal);

  // Byte enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = iStoreData;
    if (iStore) begin
      case (iFunc3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_bo;
          w_wdata = {4{iStoreData[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {w_bo[1], 1'b0};
          w_wdata = {2{iStoreData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = iStoreData;
        end
      endcase
    end else begin
      w_be    = 4'b1111;
      w_wdata = iStoreData;
    end
  end

  // Next-state, bus request, stall and completion decode.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_done  = 1'b0;
    w_fault = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memOp && !w_trap) begin
          w_req = 1'b1;
          if (iMemAck) begin
            w_done  = 1'b1;
            w_fault = iMemErr;
          end else begin
            w_stall = 1'b1;
            w_next  = WAIT;
          end
        end else if (w_trap) begin
          w_fault = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (w_timeout) begin
          // Abandon: request dropped, a coincident late ack is ignored.
          w_fault = 1'b1;
          w_next  = IDLE;
        end else if (iMemAck) begin
          w_req   = 1'b1;
          w_done  = 1'b1;
          w_fault = iMemErr;
          w_next  = IDLE;
        end else begin
          w_req   = 1'b1;
          w_stall = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_reqOut  = nRst & w_req;
  assign oMemReq   = w_reqOut;
  assign oStall    = nRst & w_stall;
  assign oMemWe    = w_reqOut & iStore;
  assign oMemAddr  = w_reqOut ? {iAluZ[RegWidth-1:2], 2'b00} : {RegWidth{1'b0}};
  assign oMemBe    = w_reqOut ? w_be : 4'b0000;
  assign oMemWData = (w_reqOut & iStore) ? w_wdata : {RegWidth{1'b0}};

  // State, wait counter and write-back result registers.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= IDLE;
      r_cnt     <= {CntW{1'b0}};
      r_valid   <= 1'b0;
      r_rdWrEn  <= 1'b0;
      r_rdAddr  <= 5'd0;
      r_rdValue <= {RegWidth{1'b0}};
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault;
      if (r_state == WAIT) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= {CntW{1'b0}};
      end
      if ((r_state == IDLE) && iValid && !iLoad && !iStore) begin
        r_valid   <= 1'b1;
        r_rdWrEn  <= iRdWrEn;
        r_rdAddr  <= iRdAddr;
        r_rdValue <= iAluZ;
      end else if (w_done && !w_fault) begin
        r_valid <= 1'b1;
        if (iLoad) begin
          r_rdWrEn  <= iRdWrEn;
          r_rdAddr  <= iRdAddr;
          r_rdValue <= load_extract(iFunc3, w_bo, iMemRData);
        end else begin
          r_rdWrEn <= 1'b0;
        end
      end else begin
        r_valid  <= 1'b0;
        r_rdWrEn <= 1'b0;
      end
    end
  end

  assign oValid   = r_valid;
  assign oRdWrEn  = r_rdWrEn;
  assign oRdAddr  = r_rdAddr;
  assign oRdValue = r_rdValue;
  assign oFault   = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TimeoutCycles=4); expectations follow MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_stage;
  logic        iClk = 1'b0;
  logic        nRst;
  logic        iValid, iLoad, iStore, iRdWrEn;
  logic [2:0]  iFunc3;
  logic [4:0]  iRdAddr;
  logic [31:0] iAluZ, iStoreData, iMemRData;
  logic        iMemAck, iMemErr;
  logic        oStall, oMemReq, oMemWe, oValid, oRdWrEn, oFault;
  logic [31:0] oMemAddr, oMemWData, oRdValue;
  logic [3:0]  oMemBe;
  logic [4:0]  oRdAddr;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;

  always #5 iClk = ~iClk;

  mem_stage #(.RegWidth(32), .TimeoutCycles(4)) dut (
    .iClk(iClk), .nRst(nRst), .iValid(iValid), .iLoad(iLoad), .iStore(iStore),
    .iFunc3(iFunc3), .iRdAddr(iRdAddr), .iRdWrEn(iRdWrEn), .iAluZ(iAluZ),
    .iStoreData(iStoreData), .oStall(oStall), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemBe(oMemBe), .oMemWData(oMemWData), .iMemAck(iMemAck),
    .iMemErr(iMemErr), .iMemRData(iMemRData), .oValid(oValid), .oRdWrEn(oRdWrEn),
    .oRdAddr(oRdAddr), .oRdValue(oRdValue), .oFault(oFault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic we, input logic [31:0] z,
                       input logic [31:0] sd);
    iValid = v; iLoad = ld; iStore = st; iFunc3 = f3;
    iRdAddr = rd; iRdWrEn = we; iAluZ = z; iStoreData = sd;
  endtask

  task automatic bus(input logic ack, input logic err, input logic [31:0] rdata);
    iMemAck = ack; iMemErr = err; iMemRData = rdata;
  endtask

  initial begin
    // Reset with a load presented: every output must stay low.
    nRst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd1, 1'b1, 32'h0000_0100, 32'h0);
    bus(1'b0, 1'b0, 32'h0);
    #3;
    chk("rst_req",   {31'd0, oMemReq}, 32'd0);
    chk("rst_stall", {31'd0, oStall},  32'd0);
    chk("rst_valid", {31'd0, oValid},  32'd0);
    chk("rst_fault", {31'd0, oFault},  32'd0);
    chk("rst_value", oRdValue,         32'd0);
    chk("rst_addr",  oMemAddr,         32'd0);
    @(negedge iClk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0);
    nRst = 1'b1;

    // ALU passthrough
    @(negedge iClk);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
    #1;
    chk("alu_stall", {31'd0, oStall},  32'd0);
    chk("alu_req",   {31'd0, oMemReq}, 32'd0);
    @(posedge iClk); #1;
    chk("alu_valid", {31'd0, oValid},  32'd1);
    chk("alu_rd",    {27'd0, oRdAddr}, 32'd5);
    chk("alu_value", oRdValue,         32'h0000_1234);
    chk("alu_we",    {31'd0, oRdWrEn}, 32'd1);

    // LB 0x103, zero-wait
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd6, 1'b1, 32'h0000_0103, 32'h0);
    bus(1'b1, 1'b0, 32'h80FF_FF00);
    #1;
    chk("lb_req",   {31'd0, oMemReq}, 32'd1);
    chk("lb_addr",  oMemAddr,         32'h0000_0100);
    chk("lb_we",    {31'd0, oMemWe},  32'd0);
    chk("lb_stall", {31'd0, oStall},  32'd0);
    @(posedge iClk); #1;
    chk("lb_valid", {31'd0, oValid},  32'd1);
    chk("lb_value", oRdValue,         32'hFFFF_FF80);
    chk("lb_rd",    {27'd0, oRdAddr}, 32'd6);

    // LBU same
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b100, 5'd7, 1'b1, 32'h0000_0103, 32'h0);
    @(posedge iClk); #1;
    chk("lbu_value", oRdValue, 32'h0000_0080);

    // LH / LHU halfword selection and extension
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b001, 5'd8, 1'b1, 32'h0000_0206, 32'h0);
    bus(1'b1, 1'b0, 32'h1234_8765);
    @(posedge iClk); #1;
    chk("lh_hi_value", oRdValue, 32'h0000_1234);
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b001, 5'd8, 1'b1, 32'h0000_0204, 32'h0);
    @(posedge iClk); #1;
    chk("lh_lo_value", oRdValue, 32'hFFFF_8765);
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b101, 5'd8, 1'b1, 32'h0000_0204, 32'h0);
    @(posedge iClk); #1;
    chk("lhu_value", oRdValue, 32'h0000_8765);

    // SB lane 1, zero-wait
    @(negedge iClk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 5'd9, 1'b1, 32'h0000_0001, 32'h0000_005A);
    #1;
    chk("sb_be",    {28'd0, oMemBe}, 32'h0000_0002);
    chk("sb_wdata", oMemWData,       32'h5A5A_5A5A);
    chk("sb_we",    {31'd0, oMemWe}, 32'd1);
    @(posedge iClk); #1;
    chk("sb_valid", {31'd0, oValid},  32'd1);
    chk("sb_rdwe",  {31'd0, oRdWrEn}, 32'd0);

    // SH 0x202 with three wait cycles
    stall_cnt = 0;
    @(negedge iClk);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 5'd10, 1'b1, 32'h0000_0202, 32'h0000_ABCD);
    bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge iClk);
      #1;
      if (oStall) stall_cnt++;
      chk("sh_req",   {31'd0, oMemReq}, 32'd1);
      chk("sh_be",    {28'd0, oMemBe},  32'h0000_000C);
      chk("sh_wdata", oMemWData,        32'hABCD_ABCD);
      chk("sh_addr",  oMemAddr,         32'h0000_0200);
      @(posedge iClk); #1;
      chk("sh_bubble", {31'd0, oValid}, 32'd0);
    end
    @(negedge iClk);
    bus(1'b1, 1'b0, 32'h0);
    #1;
    if (oStall) stall_cnt++;
    chk("sh_ack_req",  {31'd0, oMemReq}, 32'd1);
    chk("sh_stall_n",  stall_cnt,        32'd3);
    @(posedge iClk); #1;
    chk("sh_valid", {31'd0, oValid},  32'd1);
    chk("sh_rdwe",  {31'd0, oRdWrEn}, 32'd0);

    // LW with bus error on ack
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd11, 1'b1, 32'h0000_0300, 32'h0);
    bus(1'b1, 1'b1, 32'h5555_5555);
    @(posedge iClk); #1;
    chk("err_fault", {31'd0, oFault}, 32'd1);
    chk("err_valid", {31'd0, oValid}, 32'd0);
    @(negedge iClk);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1, 32'h0000_0042, 32'h0);
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk("err_idle_stall", {31'd0, oStall}, 32'd0);
    @(posedge iClk); #1;
    chk("err_fault_pulse", {31'd0, oFault}, 32'd0);
    chk("err_next_value",  oRdValue,        32'h0000_0042);

    // Timeout: no ack, request held 4 WAIT cycles then dropped
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd13, 1'b1, 32'h0000_0400, 32'h0);
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk("to_issue_req",   {31'd0, oMemReq}, 32'd1);
    chk("to_issue_stall", {31'd0, oStall},  32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk); #1;
      chk("to_wait_req",   {31'd0, oMemReq}, 32'd1);
      chk("to_wait_stall", {31'd0, oStall},  32'd1);
    end
    @(negedge iClk);
    bus(1'b1, 1'b0, 32'h7777_7777);
    #1;
    chk("to_drop_req",   {31'd0, oMemReq}, 32'd0);
    chk("to_drop_stall", {31'd0, oStall},  32'd0);
    @(posedge iClk); #1;
    chk("to_fault", {31'd0, oFault}, 32'd1);
    chk("to_valid", {31'd0, oValid}, 32'd0);
    @(negedge iClk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0);
    @(posedge iClk); #1;
    chk("to_late_fault", {31'd0, oFault}, 32'd0);
    chk("to_late_valid", {31'd0, oValid}, 32'd0);

    // Misaligned LW 0x101
    @(negedge iClk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd14, 1'b1, 32'h0000_0101, 32'h0);
    bus(1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req",   {31'd0, oMemReq}, 32'd0);
    chk("mis_stall", {31'd0, oStall},  32'd0);
    @(posedge iClk); #1;
    chk("mis_fault", {31'd0, oFault}, 32'd1);
    chk("mis_valid", {31'd0, oValid}, 32'd0);
`else
    chk("mis_req",  {31'd0, oMemReq}, 32'd1);
    chk("mis_addr", oMemAddr,         32'h0000_0100);
    @(posedge iClk); #1;
    chk("mis_value", oRdValue,        32'hDEAD_BEEF);
    chk("mis_fault", {31'd0, oFault}, 32'd0);
`endif

    // Asynchronous reset in the middle of WAIT
    @(negedge iClk);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd15, 1'b0, 32'h0000_0500, 32'h1122_3344);
    bus(1'b0, 1'b0, 32'h0);
    @(negedge iClk); #1;
    chk("rw_req_before", {31'd0, oMemReq}, 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk("rw_req_after",   {31'd0, oMemReq}, 32'd0);
    chk("rw_stall_after", {31'd0, oStall},  32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge iClk);
    nRst = 1'b1;
    @(posedge iClk); #1;
    chk("rw_valid", {31'd0, oValid},  32'd0);
    chk("rw_idle",  {31'd0, oMemReq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
